npu_act_mem_wr_arbiter: RTL and testbench
=========================================

# npu_act_mem_wr_arbiter

Round-robin arbiter that shares the single activation-memory write port among the per-MAC write requesters of the NPU layer datapath. Each cycle it accepts at most one requester's address/data, drives one registered write into the activation memory, and returns a one-cycle acknowledge pulse to the winner. It also keeps a per-layer write count, an idle indication and a sticky protocol-error flag for the control unit and status registers. It sits between the layer datapath (hw_mem_wr* buses) and the activation memory write port.

## Interface
- NUM_REQ, 32, number of requesters (1..32)
- ADDR_W, 12, activation memory address width
- DATA_W, 8, activation data width
- CNT_W, 13, width of per-layer write counter

- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- layer_start_p  in  1  one-cycle pulse at start of each layer; clears counter, pointer, error
- hw_mem_wr  in  NUM_REQ  level request per requester; held until acked
- hw_mem_wr_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- hw_mem_wr_data  in  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- hw_mem_wr_ack_p  out  NUM_REQ  one-hot one-cycle acknowledge
- act_mem_wr_en  out  1  activation memory write enable (registered)
- act_mem_wr_addr  out  ADDR_W  write address (registered)
- act_mem_wr_data  out  DATA_W  write data (registered)
- wr_count  out  CNT_W  writes issued since last layer_start_p, saturating
- arb_idle  out  1  no request pending and no write in flight
- req_drop_err  out  1  sticky: a requester dropped its request before ack

## Operation
- Eligible set in cycle C: hw_mem_wr & ~inflight_mask, where inflight_mask is one-hot of the index whose write/ack is being driven in C (zero if none).
- Winner: first eligible index scanning rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 -> 0.
- On a win in C: register winner's addr/data, set act_mem_wr_en, set hw_mem_wr_ack_p[winner] for cycle C+1; rr_ptr <= (winner+1) mod NUM_REQ.
- No eligible request: act_mem_wr_en=0, ack=0 next cycle, rr_ptr unchanged.
- Requester contract: sees ack in C+1, drops hw_mem_wr in C+2 (or re-raises with new addr/data in C+2 for a new write). The inflight mask covers C+1 so no double grant.
- wr_count increments by 1 each cycle act_mem_wr_en=1; saturates at 2^CNT_W-1.
- req_drop_err: set when, for any i, hw_mem_wr[i]=1 in cycle k, hw_mem_wr_ack_p[i]=0 in cycle k, and hw_mem_wr[i]=0 in k+1. Needs a registered copy of hw_mem_wr and ack.
- arb_idle = (hw_mem_wr == 0) && !act_mem_wr_en (combinational from inputs and registered enable).
- layer_start_p: rr_ptr<=0, wr_count<=0, req_drop_err<=0 at next edge. Same-cycle arbitration still proceeds normally and its write still issues. Clear wins over increment: a write issued in the same cycle is not counted. Clear wins over a same-cycle error set. rr_ptr<=0 wins over the pointer update.

## Timing
- Reset (resetn=0 at an edge): act_mem_wr_en=0, act_mem_wr_addr=0, act_mem_wr_data=0, hw_mem_wr_ack_p=0, wr_count=0, req_drop_err=0, rr_ptr=0, inflight_mask=0, request history=0. arb_idle follows inputs.
- Reset mid-operation: any pending grant is discarded with no ack issued. Requesters are reset by the same resetn.
- Latency: request asserted in cycle C with no contention -> write enable and ack in C+1.
- Throughput: one write per cycle. With N continuously re-requesting requesters, each is served once every N cycles.
- Worst-case wait: NUM_REQ cycles from request to ack.
- Ack and memory write are coincident (same cycle, same index). The memory sees the write at the end of that cycle.

## Test plan
- Single request: hw_mem_wr[5]=1, addr 0x123, data 0xA5 in cycle 0 -> cycle 1: act_mem_wr_en=1, addr 0x123, data 0xA5, ack=1<<5; wr_count=1 in cycle 2; no second write for index 5 in cycle 2.
- All 32 requesting from reset, each held until acked -> acks in order 0,1,...,31 on consecutive cycles 1..32; wr_count=32; arb_idle=1 afterward.
- Fairness: requesters 3 and 7 re-request immediately after each ack, rr_ptr=0 -> grant sequence 3,7,3,7,...; neither waits more than 2 cycles.
- Wrap: rr_ptr=31 (after serving 30) with requests at 31 and 0 -> 31 granted, then 0; rr_ptr ends at 1.
- Protocol error: hw_mem_wr[9]=1 for one cycle while 2 wins -> req_drop_err=1 and stays 1; layer_start_p -> req_drop_err=0, wr_count=0, next grant from index 0.
- Simultaneous layer_start_p with a write in flight -> write issues, wr_count=0 after the edge, rr_ptr=0. Reset asserted with 4 pending -> all outputs 0 the next cycle, no ack.

Source files
------------

// File: rtl/npu_act_mem_wr_arbiter.sv
// Round-robin arbiter sharing the activation-memory write port among the per-MAC
// write requesters; one registered write plus one-cycle ack per accepted request.
module npu_act_mem_wr_arbiter #(
  parameter int NUM_REQ = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 13
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      layer_start_p,
  input  logic [NUM_REQ-1:0]        hw_mem_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] hw_mem_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] hw_mem_wr_data,
  output logic [NUM_REQ-1:0]        hw_mem_wr_ack_p,
  output logic                      act_mem_wr_en,
  output logic [ADDR_W-1:0]         act_mem_wr_addr,
  output logic [DATA_W-1:0]         act_mem_wr_data,
  output logic [CNT_W-1:0]          wr_count,
  output logic                      arb_idle,
  output logic                      req_drop_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] req_p1;
  logic [NUM_REQ-1:0] ack_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // The index acked this cycle is masked so a held request is not granted twice.
  assign eligible = hw_mem_wr & ~hw_mem_wr_ack_p;

  // Stage p0: round-robin scan starting at rr_ptr
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  assign grant_onehot = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign arb_idle     = (hw_mem_wr == '0) && !act_mem_wr_en;

  // Stage p1: registered write, ack, pointer, counter and protocol history
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hw_mem_wr_ack_p <= '0;
      act_mem_wr_en   <= 1'b0;
      act_mem_wr_addr <= '0;
      act_mem_wr_data <= '0;
      wr_count        <= '0;
      req_drop_err    <= 1'b0;
      rr_ptr          <= '0;
      req_p1          <= '0;
      ack_p1          <= '0;
    end else begin
      hw_mem_wr_ack_p <= grant_onehot;
      act_mem_wr_en   <= grant_vld;
      if (grant_vld) begin
        act_mem_wr_addr <= hw_mem_wr_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        act_mem_wr_data <= hw_mem_wr_data[int'(grant_idx)*DATA_W +: DATA_W];
      end
      req_p1 <= hw_mem_wr;
      ack_p1 <= hw_mem_wr_ack_p;
      // Layer start overrides pointer advance, counting and error capture.
      if (layer_start_p) begin
        rr_ptr       <= '0;
        wr_count     <= '0;
        req_drop_err <= 1'b0;
      end else begin
        if (grant_vld) rr_ptr <= wrap_inc(grant_idx);
        if (act_mem_wr_en) wr_count <= sat_inc(wr_count);
        if (|(req_p1 & ~ack_p1 & ~hw_mem_wr)) req_drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_act_mem_wr_arbiter.sv
// Bench for npu_act_mem_wr_arbiter: cycle vector table plus scoreboarded
// requester sequences (full sweep, fairness, wrap, saturation, reset).
module tb_npu_act_mem_wr_arbiter;
  localparam int NUM_REQ = 32;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 13;

  logic                      clk = 1'b0;
  logic                      resetn;
  logic                      layer_start_p;
  logic [NUM_REQ-1:0]        hw_mem_wr;
  logic [NUM_REQ*ADDR_W-1:0] hw_mem_wr_addr;
  logic [NUM_REQ*DATA_W-1:0] hw_mem_wr_data;
  logic [NUM_REQ-1:0]        hw_mem_wr_ack_p;
  logic                      act_mem_wr_en;
  logic [ADDR_W-1:0]         act_mem_wr_addr;
  logic [DATA_W-1:0]         act_mem_wr_data;
  logic [CNT_W-1:0]          wr_count;
  logic                      arb_idle;
  logic                      req_drop_err;

  npu_act_mem_wr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .layer_start_p(layer_start_p),
    .hw_mem_wr(hw_mem_wr), .hw_mem_wr_addr(hw_mem_wr_addr), .hw_mem_wr_data(hw_mem_wr_data),
    .hw_mem_wr_ack_p(hw_mem_wr_ack_p), .act_mem_wr_en(act_mem_wr_en),
    .act_mem_wr_addr(act_mem_wr_addr), .act_mem_wr_data(act_mem_wr_data),
    .wr_count(wr_count), .arb_idle(arb_idle), .req_drop_err(req_drop_err));

  always #5 clk = ~clk;

  typedef struct {
    bit              ls;
    logic [31:0]     req;
    bit              en;
    int              ack_idx;
    logic [CNT_W-1:0] cnt;
    bit              idle;
    bit              err;
  } vec_t;

  typedef struct {
    int              idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  vec_t tbl[$];
  sb_t  sb[$];
  sb_t  mon_e;
  bit   sb_on = 1'b0;
  bit   fair_on = 1'b0;
  int   last_g[NUM_REQ];
  int   serial[NUM_REQ];
  bit   rereq[NUM_REQ];
  logic [ADDR_W-1:0] ra[NUM_REQ];
  logic [DATA_W-1:0] rd[NUM_REQ];
  logic [NUM_REQ-1:0] ack_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return ADDR_W'(12'h11E + i);
  endfunction
  function automatic logic [DATA_W-1:0] data_of(input int i);
    return DATA_W'(8'hA0 + i);
  endfunction
  function automatic logic [ADDR_W-1:0] mk_addr(input int i, input int n);
    return ADDR_W'(i * 97 + n * 13 + 7);
  endfunction
  function automatic logic [DATA_W-1:0] mk_data(input int i, input int n);
    return DATA_W'(i * 5 + n * 29 + 3);
  endfunction

  task automatic pack();
    for (int i = 0; i < NUM_REQ; i++) begin
      hw_mem_wr_addr[i*ADDR_W +: ADDR_W] = ra[i];
      hw_mem_wr_data[i*DATA_W +: DATA_W] = rd[i];
    end
  endtask

  task automatic add(input bit ls, input logic [31:0] req, input bit en, input int ack_idx,
                     input int cnt, input bit idle, input bit err);
    vec_t v;
    v.ls = ls; v.req = req; v.en = en; v.ack_idx = ack_idx;
    v.cnt = CNT_W'(cnt); v.idle = idle; v.err = err;
    tbl.push_back(v);
  endtask

  // Requester model: drop after the ack cycle, or re-raise with fresh addr/data.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_seen[i]) begin
        if (rereq[i]) begin
          serial[i]++;
          ra[i] = mk_addr(i, serial[i]);
          rd[i] = mk_data(i, serial[i]);
          sb.push_back('{idx: i, addr: ra[i], data: rd[i]});
        end else begin
          hw_mem_wr[i] = 1'b0;
        end
      end
    end
    pack();
  endtask

  task automatic raise(input int i, input bit rr);
    serial[i]++;
    ra[i] = mk_addr(i, serial[i]);
    rd[i] = mk_data(i, serial[i]);
    rereq[i] = rr;
    hw_mem_wr[i] = 1'b1;
    sb.push_back('{idx: i, addr: ra[i], data: rd[i]});
    pack();
  endtask

  task automatic ls_cycle();
    step();
    layer_start_p = 1'b1;
    step();
    layer_start_p = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write/ack must match the next expected grant.
  always @(negedge clk) begin
    ack_seen = hw_mem_wr_ack_p;
    if (sb_on && (act_mem_wr_en || hw_mem_wr_ack_p != '0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: en %0b ack %0h with nothing expected (cycle %0d)",
                 act_mem_wr_en, hw_mem_wr_ack_p, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_en", 64'(act_mem_wr_en), 64'd1);
        chk("sb_ack", 64'(hw_mem_wr_ack_p), 64'(32'(1) << mon_e.idx));
        chk("sb_addr", 64'(act_mem_wr_addr), 64'(mon_e.addr));
        chk("sb_data", 64'(act_mem_wr_data), 64'(mon_e.data));
        if (fair_on) begin
          if (last_g[mon_e.idx] >= 0) chk("fair_gap", 64'(cyc - last_g[mon_e.idx]), 64'd2);
          last_g[mon_e.idx] = cyc;
        end
      end
    end
  end

  initial begin
    // row: ls, req, en, ack_idx(-1 none), wr_count, idle, err
    add(0, 32'h0000_0020, 0, -1, 0, 0, 0);
    add(0, 32'h0000_0020, 1,  5, 0, 0, 0);
    add(0, 32'h0000_0000, 0, -1, 1, 1, 0);
    add(1, 32'h0000_0000, 0, -1, 1, 1, 0);
    add(0, 32'h0000_0204, 0, -1, 0, 0, 0);
    add(0, 32'h0000_0004, 1,  2, 0, 0, 0);
    add(0, 32'h0000_0000, 0, -1, 1, 1, 1);
    add(0, 32'h0000_0000, 0, -1, 1, 1, 1);
    add(1, 32'h0000_0010, 0, -1, 1, 0, 1);
    add(0, 32'h0000_0051, 1,  4, 0, 0, 0);
    add(0, 32'h0000_0041, 1,  0, 1, 0, 0);
    add(0, 32'h0000_0040, 1,  6, 2, 0, 0);
    add(0, 32'h0000_0000, 0, -1, 3, 1, 0);
    add(0, 32'h0000_0002, 0, -1, 3, 0, 0);
    add(1, 32'h0000_0002, 1,  1, 3, 0, 0);
    add(0, 32'h0000_0000, 0, -1, 0, 1, 0);
    add(0, 32'h0000_0009, 0, -1, 0, 0, 0);
    add(0, 32'h0000_0009, 1,  0, 0, 0, 0);
    add(0, 32'h0000_0008, 1,  3, 1, 0, 0);
    add(0, 32'h0000_0000, 0, -1, 2, 1, 0);

    resetn = 1'b0;
    layer_start_p = 1'b0;
    hw_mem_wr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      serial[i] = 0; rereq[i] = 1'b0; last_g[i] = -1;
      ra[i] = addr_of(i); rd[i] = data_of(i);
    end
    pack();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 64'(act_mem_wr_en), 64'd0);
    chk("rst_ack", 64'(hw_mem_wr_ack_p), 64'd0);
    chk("rst_addr", 64'(act_mem_wr_addr), 64'd0);
    chk("rst_data", 64'(act_mem_wr_data), 64'd0);
    chk("rst_cnt", 64'(wr_count), 64'd0);
    chk("rst_err", 64'(req_drop_err), 64'd0);
    chk("rst_idle", 64'(arb_idle), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;

    foreach (tbl[r]) begin
      @(posedge clk); #1;
      layer_start_p = tbl[r].ls;
      hw_mem_wr = tbl[r].req;
      @(negedge clk);
      chk($sformatf("row%0d_en", r), 64'(act_mem_wr_en), 64'(tbl[r].en));
      chk($sformatf("row%0d_ack", r), 64'(hw_mem_wr_ack_p),
          tbl[r].ack_idx < 0 ? 64'd0 : 64'(32'(1) << tbl[r].ack_idx));
      if (tbl[r].en) begin
        chk($sformatf("row%0d_addr", r), 64'(act_mem_wr_addr), 64'(addr_of(tbl[r].ack_idx)));
        chk($sformatf("row%0d_data", r), 64'(act_mem_wr_data), 64'(data_of(tbl[r].ack_idx)));
      end
      chk($sformatf("row%0d_cnt", r), 64'(wr_count), 64'(tbl[r].cnt));
      chk($sformatf("row%0d_idle", r), 64'(arb_idle), 64'(tbl[r].idle));
      chk($sformatf("row%0d_err", r), 64'(req_drop_err), 64'(tbl[r].err));
    end

    @(posedge clk); #1;
    layer_start_p = 1'b0;
    hw_mem_wr = '0;
    repeat (2) @(posedge clk);
    sb_on = 1'b1;

    // All 32 requesting at once: grants 0..31 on consecutive cycles.
    ls_cycle();
    for (int i = 0; i < NUM_REQ; i++) raise(i, 1'b0);
    repeat (35) step();
    @(negedge clk);
    chk("all32_cnt", 64'(wr_count), 64'd32);
    chk("all32_idle", 64'(arb_idle), 64'd1);
    chk("all32_sb_empty", 64'(sb.size()), 64'd0);

    // Fairness: 3 and 7 re-request after each ack and alternate.
    ls_cycle();
    fair_on = 1'b1;
    raise(3, 1'b1);
    raise(7, 1'b1);
    repeat (12) step();
    rereq[3] = 1'b0;
    rereq[7] = 1'b0;
    repeat (5) step();
    fair_on = 1'b0;
    @(negedge clk);
    chk("fair_sb_empty", 64'(sb.size()), 64'd0);
    chk("fair_cnt", 64'(wr_count), 64'(serial[3] + serial[7] - 2));

    // Wrap: serve 30 so the pointer sits at 31, then 31 and 0, then 5 before 0.
    ls_cycle();
    raise(30, 1'b0);
    repeat (4) step();
    raise(31, 1'b0);
    raise(0, 1'b0);
    repeat (4) step();
    raise(5, 1'b0);
    raise(0, 1'b0);
    repeat (4) step();
    @(negedge clk);
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);
    chk("wrap_cnt", 64'(wr_count), 64'd5);

    // Counter saturation under continuous full load.
    ls_cycle();
    for (int i = 0; i < NUM_REQ; i++) raise(i, 1'b1);
    repeat (8300) step();
    for (int i = 0; i < NUM_REQ; i++) rereq[i] = 1'b0;
    repeat (40) step();
    @(negedge clk);
    chk("sat_cnt", 64'(wr_count), 64'((1 << CNT_W) - 1));
    chk("sat_sb_empty", 64'(sb.size()), 64'd0);
    chk("sat_err", 64'(req_drop_err), 64'd0);

    // Reset with four pending: only the grant already made shows; nothing after.
    step();
    for (int i = 1; i <= 4; i++) raise(i, 1'b0);
    sb.delete();
    sb.push_back('{idx: 1, addr: ra[1], data: rd[1]});
    step();
    resetn = 1'b0;
    @(posedge clk); #1;
    hw_mem_wr = '0;
    @(negedge clk);
    chk("rstp_en", 64'(act_mem_wr_en), 64'd0);
    chk("rstp_ack", 64'(hw_mem_wr_ack_p), 64'd0);
    chk("rstp_addr", 64'(act_mem_wr_addr), 64'd0);
    chk("rstp_data", 64'(act_mem_wr_data), 64'd0);
    chk("rstp_cnt", 64'(wr_count), 64'd0);
    chk("rstp_err", 64'(req_drop_err), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rstp_sb_empty", 64'(sb.size()), 64'd0);
    chk("rstp_idle", 64'(arb_idle), 64'd1);
    chk("rstp_err_after", 64'(req_drop_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
